// File: rtl/div.sv
// Iterative restoring radix-2 divider (DIV/DIVU/REM/REMU), one quotient bit per cycle.
// Optional RS5_DIV_SHORTCUT_EN answers divide-by-zero and signed overflow in IDLE with no stall.
module div (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] first_operand_i,
  input  logic [31:0] second_operand_i,
  input  logic        signed_i,
  input  logic        rem_i,
  input  logic        enable_i,
  output logic        hold_o,
  output logic [31:0] result_o
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state, next_state;
  logic [31:0] dq;       // dividend on entry, quotient on exit
  logic [31:0] divisor;
  logic [31:0] rem;
  logic [4:0]  cnt;
  logic        neg_q, neg_r;

  logic        sign_a, sign_b;
  logic [31:0] mag_a, mag_b;
  logic [32:0] trial;
  logic        shortcut;
  logic [31:0] shortcut_result;
  logic        start;
  logic        hold;
  logic [31:0] result;

  assign sign_a = signed_i & first_operand_i[31];
  assign sign_b = signed_i & second_operand_i[31];
  assign mag_a  = sign_a ? -first_operand_i  : first_operand_i;
  assign mag_b  = sign_b ? -second_operand_i : second_operand_i;
  assign trial  = {rem, dq[31]} - {1'b0, divisor};

`ifdef RS5_DIV_SHORTCUT_EN
  logic div_zero, overflow;
  assign div_zero        = (second_operand_i == 32'd0);
  assign overflow        = signed_i && (first_operand_i == 32'h8000_0000)
                                    && (second_operand_i == 32'hFFFF_FFFF);
  assign shortcut        = div_zero | overflow;
  assign shortcut_result = div_zero ? (rem_i ? first_operand_i : 32'hFFFF_FFFF)
                                    : (rem_i ? 32'd0 : 32'h8000_0000);
`else
  assign shortcut        = 1'b0;
  assign shortcut_result = 32'd0;
`endif

  assign start = enable_i & ~shortcut;

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    next_state = state;
    hold       = 1'b0;
    result     = 32'd0;
    case (state)
      IDLE: begin
        hold = start;
        if (enable_i && shortcut) result = shortcut_result;
        if (start) next_state = CALC;
      end
      CALC: begin
        hold = 1'b1;
        if (cnt == 5'd0) next_state = DONE;
      end
      DONE: begin
        if (rem_i) result = neg_r ? -rem : rem;
        else       result = (neg_q && divisor != 32'd0) ? -dq : dq;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Reset blanks the outputs immediately, even while the core keeps enable_i high.
  assign hold_o   = reset_n & hold;
  assign result_o = reset_n ? result : 32'd0;

  // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      dq      <= 32'd0;
      divisor <= 32'd0;
      rem     <= 32'd0;
      cnt     <= 5'd0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: if (start) begin
          dq      <= mag_a;
          divisor <= mag_b;
          rem     <= 32'd0;
          cnt     <= 5'd31;
          neg_q   <= sign_a ^ sign_b;
          neg_r   <= sign_a;
        end
        CALC: begin
          if (!trial[32]) begin
            rem <= trial[31:0];
            dq  <= {dq[30:0], 1'b1};
          end else begin
            rem <= {rem[30:0], dq[31]};
            dq  <= {dq[30:0], 1'b0};
          end
          cnt <= cnt - 5'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
// Directed self-checking bench for div: signed/unsigned quotient and remainder,
// divide-by-zero, signed overflow, asynchronous reset mid-operation and back-to-back ops.
module tb_div;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] first_operand = 32'd0;
  logic [31:0] second_operand = 32'd0;
  logic        signed_op = 1'b0;
  logic        rem_op = 1'b0;
  logic        enable = 1'b0;
  logic        hold;
  logic [31:0] result;

  int tests = 0;
  int fails = 0;

  div dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .first_operand_i  (first_operand),
    .second_operand_i (second_operand),
    .signed_i         (signed_op),
    .rem_i            (rem_op),
    .enable_i         (enable),
    .hold_o           (hold),
    .result_o         (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Presents one instruction at a negedge and follows it to DONE, counting stall cycles.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic sg, input logic rm, input logic [31:0] exp,
                        input bit special);
    int stalls;
    int exp_stalls;
    bit partial;
    @(negedge clk);
    first_operand  = a;
    second_operand = b;
    signed_op      = sg;
    rem_op         = rm;
    enable         = 1'b1;
    #1;
    stalls  = 0;
    partial = 1'b0;
    while (hold === 1'b1 && stalls < 40) begin
      stalls++;
      if (result !== 32'd0) partial = 1'b1;
      @(negedge clk);
    end
    exp_stalls = 33;
`ifdef RS5_DIV_SHORTCUT_EN
    if (special) exp_stalls = 0;
`else
    if (special) exp_stalls = 33;
`endif
    check({tag, " stalls"}, stalls, exp_stalls);
    check({tag, " partial"}, {31'd0, partial}, 32'd0);
    check({tag, " hold"}, {31'd0, hold}, 32'd0);
    check({tag, " result"}, result, exp);
  endtask

  initial begin
    #2;
    check("reset hold", {31'd0, hold}, 32'd0);
    check("reset result", result, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    run_op("divu 100/7", 32'd100, 32'd7, 1'b0, 1'b0, 32'd14, 1'b0);
    run_op("remu 100/7", 32'd100, 32'd7, 1'b0, 1'b1, 32'd2,  1'b0);
    run_op("div -7/2",   32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 32'hFFFF_FFFD, 1'b0);
    run_op("rem -7/2",   32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0);
    run_op("rem 7/-2",   32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1, 32'd1, 1'b0);
    run_op("div x/0",    32'h1234_5678, 32'd0, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1);
    run_op("rem x/0",    32'h1234_5678, 32'd0, 1'b1, 1'b1, 32'h1234_5678, 1'b1);
    run_op("div min/0",  32'h8000_0000, 32'd0, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1);
    run_op("div ovf",    32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h8000_0000, 1'b1);
    run_op("rem ovf",    32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'd0, 1'b1);
    run_op("divu ovf",   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0, 1'b0);

    // Asynchronous reset in the middle of a division, enable still high.
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    first_operand  = 32'd100;
    second_operand = 32'd7;
    signed_op      = 1'b0;
    rem_op         = 1'b0;
    enable         = 1'b1;
    repeat (10) @(negedge clk);
    check("mid-op hold", {31'd0, hold}, 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    check("async reset hold", {31'd0, hold}, 32'd0);
    check("async reset result", result, 32'd0);
    @(negedge clk);
    enable  = 1'b0;
    reset_n = 1'b1;
    run_op("divu after reset", 32'd100, 32'd7, 1'b0, 1'b0, 32'd14, 1'b0);

    // Back-to-back instructions with enable held high across the boundary.
    @(negedge clk);
    enable = 1'b0;
    run_op("b2b divu", 32'hFFFF_FFFF, 32'd1,  1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0);
    run_op("b2b remu", 32'hFFFF_FFFF, 32'h10, 1'b0, 1'b1, 32'h0000_000F, 1'b0);

    @(negedge clk);
    enable = 1'b0;
    #1;
    check("idle hold", {31'd0, hold}, 32'd0);
    check("idle result", result, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
